gcd_dispatch: RTL and testbench
===============================

GCD_DISPATCH -- requirements
Module: gcd_dispatch

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the operand FIFO entries; DEPTH is a power of two and at least 2.
REQ-003 clk  input  1  Clock; all state updates on its rising edge.
REQ-004 reset  input  1  Synchronous, active-high reset.
REQ-005 in_valid  input  1  An operand pair is offered.
REQ-006 in_ready  output  1  FIFO can accept a pair; equals "not full".
REQ-007 in_a, in_b  input  WIDTH  Operand pair.
REQ-008 core_start  output  1  Start request to the downstream GCD engine.
REQ-009 core_a, core_b  output  WIDTH  Operands to the engine; held stable while a job is in flight.
REQ-010 core_finished  input  1  Engine done pulse or level.
REQ-011 core_result  input  WIDTH  Engine result; valid when core_finished=1.
REQ-012 out_valid  output  1  Result available.
REQ-013 out_ready  input  1  Consumer accepts the result.
REQ-014 out_gcd  output  WIDTH  GCD result.
REQ-015 out_bypass  output  1  Result produced without the engine (zero operand).

Function
REQ-016 The FIFO SHALL write when in_valid and in_ready are both 1, and SHALL pop when the FSM leaves IDLE with a job.
- Pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH.
- Full is pointer MSBs differing with equal low bits; empty is equal pointers.
- A simultaneous push and pop when full is illegal, because in_ready=0 blocks the push.
- A simultaneous push and pop when neither full nor empty leaves the count unchanged.
REQ-017 The FSM SHALL have the states IDLE, LAUNCH, WAIT, DRAIN and OUT.
REQ-018 IDLE, when FIFO is non-empty and out_valid=0: pop the head into the core_a/core_b registers.
- If either operand is 0, go to OUT with out_gcd = in_a|in_b (the nonzero one, or 0 if both are 0) and out_bypass=1.
- Otherwise go to LAUNCH.
REQ-019 LAUNCH SHALL assert core_start=1 for exactly one cycle, then go to WAIT.
REQ-020 WAIT SHALL keep core_start=0 and, on core_finished=1, capture core_result into out_gcd with out_bypass=0, then go to DRAIN.
REQ-021 DRAIN SHALL wait one cycle with core_start=0 so the engine returns to its start-check state, then go to OUT.
REQ-022 OUT SHALL hold out_valid=1 with out_gcd and out_bypass stable until out_ready=1, then return to IDLE on the next edge.
REQ-023 Job latency from pop to out_valid SHALL be:
- bypass: 1 cycle;
- engine: 3 cycles plus the engine run time (LAUNCH, WAIT cycles, DRAIN).
REQ-024 At most one job SHALL be in flight; results leave in the same order operands arrived.
REQ-025 Input acceptance SHALL continue in every state while the FIFO is not full.
REQ-026 core_start SHALL never be asserted outside LAUNCH.

Reset
REQ-027 On reset=1 at a clock edge, the block SHALL:
- empty the FIFO (both pointers 0);
- go to FSM state IDLE;
- drive core_start=0, core_a=0, core_b=0, out_valid=0, out_gcd=0, out_bypass=0;
- drive in_ready=1 from the first cycle after reset.
REQ-028 Reset in any state, including WAIT mid-job, SHALL discard the in-flight job and all queued pairs, and SHALL NOT assert out_valid until a new pair is accepted.
REQ-029 The block SHALL NOT drive the engine's reset; the engine shares reset.

Verification
REQ-030 Push (48,18) with out_ready=1 and an engine model -> one core_start pulse with core_a=48, core_b=18; then out_valid=1, out_gcd=6, out_bypass=0.
REQ-031 Push (0,35) -> no core_start; out_valid=1 one cycle after the pop, out_gcd=35, out_bypass=1; push (0,0) -> out_gcd=0, out_bypass=1.
REQ-032 With out_ready=0 and no pops, push 4 pairs at DEPTH=4 -> in_ready=0 after the 4th; a 5th in_valid is not accepted; release out_ready -> results emerge in push order.
REQ-033 Hold out_ready=0 for 10 cycles with a result pending -> out_valid, out_gcd and out_bypass stay stable and no new core_start is issued.
REQ-034 Assert reset during WAIT of job (21,14) -> no out_valid for that job; FIFO empty; a subsequent push (9,6) yields out_gcd=3.
REQ-035 Push 2*DEPTH+3 pairs continuously with out_ready=1 -> pointers wrap and every result matches a reference GCD in order.

Source files
------------

// File: rtl/gcd_dispatch_if.sv
// Handshake bundle for gcd_dispatch: operand input, engine control and result output.
interface gcd_dispatch_if #(parameter int WIDTH = 8);
  logic             in_valid, in_ready;
  logic [WIDTH-1:0] in_a, in_b;
  logic             core_start, core_finished;
  logic [WIDTH-1:0] core_a, core_b, core_result;
  logic             out_valid, out_ready, out_bypass;
  logic [WIDTH-1:0] out_gcd;

  modport slave (
    input  in_valid, in_a, in_b, core_finished, core_result, out_ready,
    output in_ready, core_start, core_a, core_b, out_valid, out_gcd, out_bypass
  );
  modport master (
    output in_valid, in_a, in_b, core_finished, core_result, out_ready,
    input  in_ready, core_start, core_a, core_b, out_valid, out_gcd, out_bypass
  );
endinterface

// File: rtl/gcd_dispatch.sv
// Operand FIFO feeding one external GCD engine, one job in flight; zero operands
// are resolved locally without starting the engine.
module gcd_dispatch #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input logic          clk,
  input logic          reset,
  gcd_dispatch_if.slave io
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_DRAIN, S_OUT} state_t;

  state_t             state_q, state_d;
  logic [AW:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2*WIDTH-1:0] mem_q [DEPTH];
  logic [2*WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0]   core_a_q, core_a_d, core_b_q, core_b_d, out_gcd_q, out_gcd_d;
  logic               out_bypass_q, out_bypass_d;

  logic               full, empty, push, pop;
  logic [WIDTH-1:0]   head_a, head_b;

  // Extra pointer bit tells full from empty when the low bits match.
  assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign push   = io.in_valid && !full;
  assign pop    = (state_q == S_IDLE) && !empty;
  assign head_a = mem_q[rd_ptr_q[AW-1:0]][2*WIDTH-1:WIDTH];
  assign head_b = mem_q[rd_ptr_q[AW-1:0]][WIDTH-1:0];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = {io.in_a, io.in_b};
      wr_ptr_d                = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    core_a_d     = core_a_q;
    core_b_d     = core_b_q;
    out_gcd_d    = out_gcd_q;
    out_bypass_d = out_bypass_q;
    case (state_q)
      S_IDLE: if (!empty) begin
        core_a_d = head_a;
        core_b_d = head_b;
        if (head_a == '0 || head_b == '0) begin
          out_gcd_d    = head_a | head_b;
          out_bypass_d = 1'b1;
          state_d      = S_OUT;
        end else begin
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT: if (io.core_finished) begin
        out_gcd_d    = io.core_result;
        out_bypass_d = 1'b0;
        state_d      = S_DRAIN;
      end
      // One idle cycle lets the engine fall back to checking for start.
      S_DRAIN: state_d = S_OUT;
      S_OUT:   if (io.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      core_a_q     <= '0;
      core_b_q     <= '0;
      out_gcd_q    <= '0;
      out_bypass_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      core_a_q     <= core_a_d;
      core_b_q     <= core_b_d;
      out_gcd_q    <= out_gcd_d;
      out_bypass_q <= out_bypass_d;
    end
  end

  // Storage needs no reset: empty pointers mask stale entries.
  always_ff @(posedge clk) mem_q <= mem_d;

  assign io.in_ready   = !full;
  assign io.core_start = (state_q == S_LAUNCH);
  assign io.core_a     = core_a_q;
  assign io.core_b     = core_b_q;
  assign io.out_valid  = (state_q == S_OUT);
  assign io.out_gcd    = out_gcd_q;
  assign io.out_bypass = out_bypass_q;
endmodule

// File: tb/tb_gcd_dispatch.sv
// Directed bench for gcd_dispatch with a subtractive GCD engine model.
module tb_gcd_dispatch;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  gcd_dispatch_if #(.WIDTH(8)) io ();
  gcd_dispatch #(.WIDTH(8), .DEPTH(4)) dut (.clk(clk), .reset(reset), .io(io));

  // Engine model: one subtraction step per cycle, finish pulse when equal.
  logic [7:0] ea, eb, eres;
  logic       ebusy, efin;
  always @(posedge clk) begin
    if (reset) begin
      ea <= '0; eb <= '0; eres <= '0; ebusy <= 1'b0; efin <= 1'b0;
    end else begin
      efin <= 1'b0;
      if (io.core_start) begin
        ea <= io.core_a; eb <= io.core_b; ebusy <= 1'b1;
      end else if (ebusy) begin
        if (ea == eb) begin
          efin <= 1'b1; eres <= ea; ebusy <= 1'b0;
        end else if (ea > eb) ea <= ea - eb;
        else eb <= eb - ea;
      end
    end
  end
  assign io.core_finished = efin;
  assign io.core_result   = eres;

  int n_tests = 0;
  int n_fail  = 0;
  int n_start = 0;
  logic [8:0] res_q[$];

  // Sample just after the negedge drive, i.e. what the next posedge will see.
  always begin
    @(negedge clk); #2;
    if (io.core_start) n_start++;
    if (io.out_valid && io.out_ready) res_q.push_back({io.out_bypass, io.out_gcd});
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    io.in_valid = 1'b1; io.in_a = a; io.in_b = b;
    while (!io.in_ready && n < 500) begin @(negedge clk); n++; end
    chk("push_ready", {31'd0, io.in_ready}, 1);
    @(negedge clk);
    io.in_valid = 1'b0;
  endtask

  task automatic wait_start();
    int n = 0;
    while (!io.core_start && n < 100) begin @(negedge clk); n++; end
    chk("start_seen", {31'd0, io.core_start}, 1);
  endtask

  task automatic wait_res(input int want);
    int n = 0;
    while (res_q.size() < want && n < 2000) begin @(negedge clk); n++; end
    chk("res_count", res_q.size(), want);
  endtask

  logic [7:0] a35 [11] = '{8'd48, 8'd17, 8'd100, 8'd0,  8'd64, 8'd27, 8'd35, 8'd20, 8'd81, 8'd50, 8'd13};
  logic [7:0] b35 [11] = '{8'd36, 8'd5,  8'd75,  8'd13, 8'd48, 8'd18, 8'd49, 8'd0,  8'd54, 8'd30, 8'd13};
  logic [7:0] g35 [11] = '{8'd12, 8'd1,  8'd25,  8'd13, 8'd16, 8'd9,  8'd7,  8'd20, 8'd27, 8'd10, 8'd13};
  logic       y35 [11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [7:0] g32 [5]  = '{8'd4, 8'd7, 8'd5, 8'd9, 8'd7};
  logic       y32 [5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    int base, s0, seen;
    reset = 1'b1; io.in_valid = 1'b0; io.in_a = '0; io.in_b = '0; io.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_in_ready", {31'd0, io.in_ready}, 1);
    chk("rst_out_valid", {31'd0, io.out_valid}, 0);
    chk("rst_core_start", {31'd0, io.core_start}, 0);
    chk("rst_core_a", {24'd0, io.core_a}, 0);
    chk("rst_core_b", {24'd0, io.core_b}, 0);
    chk("rst_out_gcd", {24'd0, io.out_gcd}, 0);
    chk("rst_out_bypass", {31'd0, io.out_bypass}, 0);

    // Engine job (48,18)
    s0 = n_start; base = res_q.size();
    push(8'd48, 8'd18);
    wait_start();
    chk("launch_a", {24'd0, io.core_a}, 48);
    chk("launch_b", {24'd0, io.core_b}, 18);
    wait_res(base + 1);
    chk("gcd_48_18", {23'd0, res_q[base]}, {23'd0, 1'b0, 8'd6});
    chk("start_pulses", n_start - s0, 1);

    // Bypass jobs (0,35) and (0,0)
    s0 = n_start; base = res_q.size();
    push(8'd0, 8'd35);
    chk("byp_pre_valid", {31'd0, io.out_valid}, 0);
    @(negedge clk);
    chk("byp_valid", {31'd0, io.out_valid}, 1);
    chk("byp_gcd", {24'd0, io.out_gcd}, 35);
    chk("byp_flag", {31'd0, io.out_bypass}, 1);
    push(8'd0, 8'd0);
    wait_res(base + 2);
    chk("byp_0_35", {23'd0, res_q[base]}, {23'd0, 1'b1, 8'd35});
    chk("byp_0_0", {23'd0, res_q[base+1]}, {23'd0, 1'b1, 8'd0});
    chk("byp_no_start", n_start - s0, 0);

    // Back-pressure: one job stalled in OUT, FIFO filled behind it
    @(negedge clk);
    io.out_ready = 1'b0;
    base = res_q.size();
    push(8'd12, 8'd8);
    seen = 0;
    while (!io.out_valid && seen < 200) begin @(negedge clk); seen++; end
    chk("stall_valid", {31'd0, io.out_valid}, 1);
    push(8'd0, 8'd7);
    push(8'd15, 8'd25);
    push(8'd9, 8'd0);
    push(8'd14, 8'd21);
    chk("full_ready", {31'd0, io.in_ready}, 0);
    io.in_valid = 1'b1; io.in_a = 8'd99; io.in_b = 8'd33;
    repeat (3) @(negedge clk);
    chk("full_reject", {31'd0, io.in_ready}, 0);
    io.in_valid = 1'b0;
    s0 = n_start;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_valid", {31'd0, io.out_valid}, 1);
      chk("hold_gcd", {24'd0, io.out_gcd}, 4);
      chk("hold_bypass", {31'd0, io.out_bypass}, 0);
    end
    chk("hold_no_start", n_start - s0, 0);
    io.out_ready = 1'b1;
    wait_res(base + 5);
    repeat (30) @(negedge clk);
    chk("order_count", res_q.size(), base + 5);
    for (int i = 0; i < 5; i++)
      chk($sformatf("order_%0d", i), {23'd0, res_q[base+i]}, {23'd0, y32[i], g32[i]});

    // Reset while the engine is working on (21,14)
    base = res_q.size();
    push(8'd21, 8'd14);
    wait_start();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_ready", {31'd0, io.in_ready}, 1);
    chk("mid_rst_valid", {31'd0, io.out_valid}, 0);
    chk("mid_rst_core_a", {24'd0, io.core_a}, 0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (io.out_valid) seen++;
    end
    chk("mid_rst_quiet", seen, 0);
    chk("mid_rst_nores", res_q.size(), base);
    push(8'd9, 8'd6);
    wait_res(base + 1);
    chk("gcd_9_6", {23'd0, res_q[base]}, {23'd0, 1'b0, 8'd3});

    // Pointer wrap: 2*DEPTH+3 jobs streamed back to back
    base = res_q.size();
    for (int i = 0; i < 11; i++) push(a35[i], b35[i]);
    wait_res(base + 11);
    for (int i = 0; i < 11; i++)
      chk($sformatf("wrap_%0d", i), {23'd0, res_q[base+i]}, {23'd0, y35[i], g35[i]});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
